thr_slew_ctrl: RTL and testbench
================================

THR_SLEW_CTRL -- requirements
Module: thr_slew_ctrl

Interface
REQ-001 Parameter TW, 7: threshold width in bits.
REQ-002 Parameter CNT_W, 32: period counter width.
REQ-003 Parameter PERIOD, 20_000_000: clock cycles between timer-mode steps; legal range 2..2^CNT_W-1.
REQ-004 Parameter STEP, 1: maximum change of T per step; legal range 1..2^TW-1.
REQ-005 Parameter T_MIN, 8 and T_MAX, 11: inclusive output clamp; T_MIN <= T_MAX required.
REQ-006 Parameter T_INIT, 8: reset value of T; T_MIN <= T_INIT <= T_MAX required.
REQ-007 Parameter HYST, 0: dead-band; no step while |target - T| <= HYST.
REQ-008 clock  in  1  system clock; all logic rising-edge.
REQ-009 rst_n  in  1  reset, asynchronous, active-low.
REQ-010 iT_target  in  TW  raw threshold from the Otsu datapath.
REQ-011 iT_vld  in  1  one-cycle qualifier for iT_target.
REQ-012 vs  in  1  frame sync; rising edge marks frame start.
REQ-013 mode  in  2  00 timer, 01 frame-sync, 10 freeze, 11 bypass.
REQ-014 T  out  TW  registered, slew-limited, clamped threshold.
REQ-015 T_upd  out  1  one-cycle pulse in the cycle after T changes value.
REQ-016 settled  out  1  high while T is within HYST of the latched target or pinned at a clamp limit in the target's direction.

Function
REQ-017 Target register tgt loads iT_target on the cycle iT_vld=1; otherwise it holds.
REQ-018 FSM states: NOTGT (no target since reset), TRACK (|tgt-T|>HYST and not pinned), SETTLED; NOTGT->TRACK/SETTLED on first iT_vld; TRACK<->SETTLED evaluated every cycle from registered tgt and T.
REQ-019 In NOTGT no step is taken; T holds T_INIT; settled=0.
REQ-020 Tick, timer mode: counter counts 0..PERIOD-1 and wraps; tick asserted when counter==PERIOD-1.
REQ-021 Tick, frame-sync mode: vs registered once; tick asserted one cycle after a detected rising edge; counter held at 0.
REQ-022 Freeze mode: no tick; T holds; counter held at 0; tgt still loads.
REQ-023 Any change of mode clears the counter to 0 in the following cycle; no tick in the change cycle.
REQ-024 Step on tick in TRACK: if tgt > T+HYST, T <= min(T+STEP, tgt, T_MAX); if tgt+HYST < T, T <= max(T-STEP, tgt, T_MIN); otherwise hold.
REQ-025 Step arithmetic in TW+1 bits; no wrap-around at 2^TW-1 or 0.
REQ-026 Bypass mode: T <= clamp(tgt, T_MIN, T_MAX) every cycle (1-cycle latency from tgt, 2 from iT_vld); STEP and HYST ignored; counter held at 0.
REQ-027 Simultaneous iT_vld and tick: the step uses the previously latched tgt; the new target affects the next tick.
REQ-028 Target outside [T_MIN,T_MAX]: T moves toward the target and stops at the limit; state becomes SETTLED when pinned.
REQ-029 T_upd asserts for exactly one cycle per change of T, in every mode; never when T holds.

Reset
REQ-030 rst_n low asynchronously forces T=T_INIT, tgt=T_INIT, counter=0, vs register=0, FSM=NOTGT, T_upd=0, settled=0.
REQ-031 Reset release mid-frame: the first vs rising edge after release counts as a tick; a vs already high at release produces no tick.

Verification
REQ-032 Timer (PERIOD=4, STEP=1, defaults); iT_target=11 pulse -> T 8->9->10->11 on consecutive ticks 4 cycles apart; 3 T_upd pulses; settled=1 at 11.
REQ-033 Clamp: T_MAX=11, iT_target=20 -> T stops at 11; settled=1; no further T_upd over 10 ticks.
REQ-034 Hysteresis: HYST=1, T=10, iT_target=11 -> no step; settled=1; iT_target=12 -> T=11 on next tick.
REQ-035 Frame-sync: mode=01, iT_target=8, T=11, STEP=2 -> each vs rising edge steps 11->9->8; nothing between edges.
REQ-036 Bypass/freeze: mode=11, iT_target=3 -> T=8 (clamp) 2 cycles after iT_vld; mode=10 then iT_target=11 -> T holds at 8 indefinitely.
REQ-037 Async reset mid-run with T=10 -> T=8, T_upd=0, settled=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/thr_slew_ctrl.sv
// Slew-limited, clamped threshold tracker: T follows the latched target one bounded step per tick (timer, frame sync) or directly (bypass).
// T is registered (1 cycle from tgt, 2 from iT_vld in bypass); no backpressure, iT_vld is always accepted.
module thr_slew_ctrl #(
    parameter int     TW     = 7,
    parameter int     CNT_W  = 32,
    parameter longint PERIOD = 20_000_000,
    parameter int     STEP   = 1,
    parameter int     T_MIN  = 8,
    parameter int     T_MAX  = 11,
    parameter int     T_INIT = 8,
    parameter int     HYST   = 0
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic [TW-1:0] iT_target,
    input  logic          iT_vld,
    input  logic          vs,
    input  logic [1:0]    mode,
    output logic [TW-1:0] T,
    output logic          T_upd,
    output logic          settled
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [TW:0]      STEP_E   = (TW+1)'(STEP);
    localparam logic [TW:0]      HYST_E   = (TW+1)'(HYST);
    localparam logic [TW:0]      TMIN_E   = (TW+1)'(T_MIN);
    localparam logic [TW:0]      TMAX_E   = (TW+1)'(T_MAX);
    localparam logic [TW-1:0]    T_INIT_V = TW'(T_INIT);

    localparam logic [1:0] M_TIMER  = 2'b00;
    localparam logic [1:0] M_FSYNC  = 2'b01;
    localparam logic [1:0] M_BYPASS = 2'b11;

    typedef enum logic [1:0] {NOTGT, TRACK, SETTLED} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    tgt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             vs_q, rise_q, armed;
    logic [1:0]       mode_q;

    logic [TW:0] t_e, g_e, up_raw, dn_raw, up_val, dn_val, byp_val, t_nxt;
    logic        up_want, dn_want, mode_chg, tick;

    // Settled means inside the dead-band, or pinned at the clamp the target pushes against.
    function automatic logic settle_chk(input logic [TW:0] g, input logic [TW:0] t);
        logic up, dn;
        up = g > (t + HYST_E);
        dn = (g + HYST_E) < t;
        return (!up && !dn) || (up && t >= TMAX_E) || (dn && t <= TMIN_E);
    endfunction

    always_comb begin
        t_e     = {1'b0, T};
        g_e     = {1'b0, tgt};
        up_want = g_e > (t_e + HYST_E);
        dn_want = (g_e + HYST_E) < t_e;
        up_raw  = t_e + STEP_E;
        dn_raw  = (t_e > STEP_E) ? (t_e - STEP_E) : '0;

        up_val = up_raw;
        if (g_e < up_val)    up_val = g_e;
        if (TMAX_E < up_val) up_val = TMAX_E;
        dn_val = dn_raw;
        if (g_e > dn_val)    dn_val = g_e;
        if (TMIN_E > dn_val) dn_val = TMIN_E;
        byp_val = g_e;
        if (g_e > TMAX_E)    byp_val = TMAX_E;
        if (g_e < TMIN_E)    byp_val = TMIN_E;

        // armed masks the first cycle after reset, when neither vs nor mode has a valid history.
        mode_chg = armed && (mode != mode_q);
        tick     = !mode_chg && (((mode == M_TIMER) && (cnt == CNT_LAST)) ||
                                 ((mode == M_FSYNC) && rise_q));

        cnt_nxt = cnt + CNT_W'(1);
        if (mode_chg || (mode != M_TIMER) || (cnt == CNT_LAST)) cnt_nxt = '0;

        t_nxt = t_e;
        if (state != NOTGT) begin
            if (mode == M_BYPASS)  t_nxt = byp_val;
            else if (tick) begin
                if (up_want)       t_nxt = up_val;
                else if (dn_want)  t_nxt = dn_val;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            NOTGT: begin
                if (iT_vld) state_nxt = settle_chk({1'b0, iT_target}, t_e) ? SETTLED : TRACK;
            end
            default: state_nxt = settle_chk(g_e, t_e) ? SETTLED : TRACK;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= NOTGT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            T      <= T_INIT_V;
            tgt    <= T_INIT_V;
            cnt    <= '0;
            vs_q   <= 1'b0;
            rise_q <= 1'b0;
            armed  <= 1'b0;
            mode_q <= M_TIMER;
            T_upd  <= 1'b0;
        end else begin
            if (iT_vld) tgt <= iT_target;
            T      <= t_nxt[TW-1:0];
            T_upd  <= (t_nxt != t_e);
            cnt    <= cnt_nxt;
            vs_q   <= vs;
            rise_q <= vs & ~vs_q & armed;
            armed  <= 1'b1;
            mode_q <= mode;
        end
    end

    assign settled = (state == SETTLED);

endmodule

// File: tb/tb_thr_slew_ctrl.sv
// Bench for thr_slew_ctrl: three parameterisations, expected T values queued per instance and popped on each T_upd.
module tb_thr_slew_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic vs;
    always #5 clk = ~clk;

    // a: STEP=1 HYST=0, b: STEP=2 HYST=0 (frame sync), c: STEP=1 HYST=1; all PERIOD=4
    logic [6:0] tgt_a, tgt_b, tgt_c, T_a, T_b, T_c;
    logic       vld_a, vld_b, vld_c, upd_a, upd_b, upd_c, st_a, st_b, st_c;
    logic [1:0] mode_a, mode_b, mode_c;

    thr_slew_ctrl #(.PERIOD(4), .STEP(1), .HYST(0)) u_a (
        .clock(clk), .rst_n(rst_n), .iT_target(tgt_a), .iT_vld(vld_a), .vs(vs),
        .mode(mode_a), .T(T_a), .T_upd(upd_a), .settled(st_a));
    thr_slew_ctrl #(.PERIOD(4), .STEP(2), .HYST(0)) u_b (
        .clock(clk), .rst_n(rst_n), .iT_target(tgt_b), .iT_vld(vld_b), .vs(vs),
        .mode(mode_b), .T(T_b), .T_upd(upd_b), .settled(st_b));
    thr_slew_ctrl #(.PERIOD(4), .STEP(1), .HYST(1)) u_c (
        .clock(clk), .rst_n(rst_n), .iT_target(tgt_c), .iT_vld(vld_c), .vs(vs),
        .mode(mode_c), .T(T_c), .T_upd(upd_c), .settled(st_c));

    int n_cmp = 0;
    int n_bad = 0;
    int qa[$];
    int qb[$];
    int qc[$];
    int cyc = 0;
    logic gap_on = 1'b0;

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    int last_cyc = -1;
    always @(negedge clk) begin
        if (upd_a) begin
            if (qa.size() != 0) chk_eq("a_T_on_upd", int'(T_a), qa.pop_front());
            else                chk_eq("a_spurious_upd", qa.size(), 1);
            if (gap_on && last_cyc >= 0) chk_eq("a_tick_gap", cyc - last_cyc, 4);
            last_cyc = cyc;
        end
        if (!gap_on) last_cyc = -1;
    end

    always @(negedge clk) begin
        if (upd_b) begin
            if (qb.size() != 0) chk_eq("b_T_on_upd", int'(T_b), qb.pop_front());
            else                chk_eq("b_spurious_upd", qb.size(), 1);
        end
        if (upd_c) begin
            if (qc.size() != 0) chk_eq("c_T_on_upd", int'(T_c), qc.pop_front());
            else                chk_eq("c_spurious_upd", qc.size(), 1);
        end
    end

    initial begin
        rst_n = 1'b1; vs = 1'b0;
        tgt_a = '0; tgt_b = '0; tgt_c = '0;
        vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
        mode_a = 2'b00; mode_b = 2'b01; mode_c = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_T", int'(T_a), 8);
        chk_eq("rst_upd", int'(upd_a), 0);
        chk_eq("rst_settled", int'(st_a), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(6);
        chk_eq("notgt_T", int'(T_a), 8);
        chk_eq("notgt_settled", int'(st_a), 0);

        // timer: 8 -> 9 -> 10 -> 11, ticks four cycles apart
        gap_on = 1'b1;
        tgt_a = 7'd11; vld_a = 1'b1;
        qa.push_back(9); qa.push_back(10); qa.push_back(11);
        step(1); vld_a = 1'b0;
        step(20);
        gap_on = 1'b0;
        chk_eq("timer_T_final", int'(T_a), 11);
        chk_eq("timer_settled", int'(st_a), 1);

        // target above T_MAX: pinned, no further updates over > 10 ticks
        tgt_a = 7'd20; vld_a = 1'b1;
        step(1); vld_a = 1'b0;
        step(45);
        chk_eq("clamp_T", int'(T_a), 11);
        chk_eq("clamp_settled", int'(st_a), 1);

        // bypass: target 3 clamps to 8, two cycles after iT_vld
        mode_a = 2'b11;
        step(2);
        tgt_a = 7'd3; vld_a = 1'b1; qa.push_back(8);
        step(1); vld_a = 1'b0;
        chk_eq("byp_lat1_T", int'(T_a), 11);
        step(1);
        chk_eq("byp_lat2_T", int'(T_a), 8);

        // freeze: target still loads, T holds
        mode_a = 2'b10;
        tgt_a = 7'd11; vld_a = 1'b1;
        step(1); vld_a = 1'b0;
        step(30);
        chk_eq("freeze_T", int'(T_a), 8);
        chk_eq("freeze_settled", int'(st_a), 0);
        tgt_a = 7'd10; vld_a = 1'b1;
        step(1); vld_a = 1'b0;
        step(3);

        // back to timer: counter restarts after the change cycle, first step 5 edges later
        qa.push_back(9); qa.push_back(10);
        mode_a = 2'b00;
        step(4);
        chk_eq("modechg_no_early", int'(T_a), 8);
        step(1);
        chk_eq("modechg_first_step", int'(T_a), 9);
        step(4);
        chk_eq("prerst_T", int'(T_a), 10);
        chk_eq("prerst_upd", int'(upd_a), 1);

        // asynchronous reset between clock edges, with vs high across release
        #6;
        rst_n = 1'b0; vs = 1'b1; tgt_b = 7'd11;
        #1;
        chk_eq("arst_T", int'(T_a), 8);
        chk_eq("arst_upd", int'(upd_a), 0);
        chk_eq("arst_settled", int'(st_a), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vld_b = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1 vld_b = 1'b0;
        step(12);
        chk_eq("vs_high_at_release_T", int'(T_b), 8);

        // hysteresis HYST=1: target 11 stops at 10, then 12 reaches 11
        tgt_c = 7'd11; vld_c = 1'b1;
        qc.push_back(9); qc.push_back(10);
        step(1); vld_c = 1'b0;
        step(20);
        chk_eq("hyst_T_dead_band", int'(T_c), 10);
        chk_eq("hyst_settled", int'(st_c), 1);
        tgt_c = 7'd12; vld_c = 1'b1; qc.push_back(11);
        step(1); vld_c = 1'b0;
        step(10);
        chk_eq("hyst_T_after_12", int'(T_c), 11);
        chk_eq("hyst_settled_pinned", int'(st_c), 1);

        // frame sync STEP=2: 8 -> 10 -> 11 toward 11, then 11 -> 9 -> 8 toward 8
        qb.push_back(10);
        vs = 1'b0; step(3);
        vs = 1'b1;
        step(1);
        chk_eq("fs_no_early_T", int'(T_b), 8);
        step(1);
        chk_eq("fs_edge_T", int'(T_b), 10);
        step(6);
        chk_eq("fs_hold_between", int'(T_b), 10);
        qb.push_back(11);
        vs = 1'b0; step(3); vs = 1'b1; step(4);
        chk_eq("fs_T_11", int'(T_b), 11);
        tgt_b = 7'd8; vld_b = 1'b1;
        step(1); vld_b = 1'b0;
        qb.push_back(9); qb.push_back(8);
        vs = 1'b0; step(3); vs = 1'b1; step(4);
        chk_eq("fs_down_T_9", int'(T_b), 9);
        vs = 1'b0; step(3); vs = 1'b1; step(4);
        chk_eq("fs_down_T_8", int'(T_b), 8);
        chk_eq("fs_settled", int'(st_b), 1);

        step(10);
        chk_eq("a_sb_drain", qa.size(), 0);
        chk_eq("b_sb_drain", qb.size(), 0);
        chk_eq("c_sb_drain", qc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
